wb_cmd_master: RTL and testbench
================================

Name: wb_cmd_master

Overview:
- Synthesizable Wishbone classic single-transfer initiator (master side). Complements the memory, UART and test-core responders of the lm32 SoC bench.
- Accepts read/write commands over a valid/ready interface and runs one Wishbone cycle per command.
- Returns read data and a completion status over a valid/ready response interface.
- Handles ERR, RTY with bounded retries, and a timeout. Drives data-bus-style slaves (e.g. 0xff000000 UART, 0xffff0000 test core) from a scripted source.

Parameters:
- TIMEOUT, 1024, cycles with CYC asserted and no termination before abort; 0 disables the timeout.
- MAX_RETRY, 3, number of reissues after RTY before giving up.

Ports:
- sys_clk  in  1  clock.
- sys_rst  in  1  asynchronous reset, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a posedge.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_adr  in  32  byte address.
- cmd_dat  in  32  write data.
- cmd_sel  in  4  byte lanes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready at a posedge.
- rsp_dat  out  32  read data; 0 for writes and failed reads.
- rsp_status  out  2  00 OK, 01 ERR, 10 TIMEOUT, 11 RETRY_EXHAUSTED.
- wb_adr_o  out  32  address, bits [1:0] forced to 0.
- wb_dat_o  out  32  write data.
- wb_dat_i  in  32  read data.
- wb_sel_o  out  4  byte select.
- wb_we_o  out  1  write enable.
- wb_cyc_o  out  1  cycle.
- wb_stb_o  out  1  strobe.
- wb_cti_o  out  3  constant 3'b000 (classic).
- wb_bte_o  out  2  constant 2'b00.
- wb_ack_i  in  1  acknowledge.
- wb_err_i  in  1  error.
- wb_rty_i  in  1  retry.

Behaviour:
- Reset (async) values:
  - state = IDLE.
  - cmd_ready = 1.
  - rsp_valid = 0.
  - wb_cyc_o = wb_stb_o = wb_we_o = 0.
  - wb_adr_o, wb_dat_o, wb_sel_o, rsp_dat, rsp_status all 0.
  - Retry and timeout counters 0.
- Reset mid-cycle: CYC/STB drop asynchronously. The in-flight command and any pending response are discarded; nothing is replayed.
- cmd_ready = (state == IDLE), registered. Only one command is outstanding at a time.
- IDLE:
  - On command handshake at edge N, latch adr/dat/sel/we into wb_*_o.
  - CYC = STB = 1 from edge N.
  - Clear retry and timeout counters.
  - Go to BUS.
- BUS: terminations are sampled at each posedge. Priority is err > rty > ack.
  - err: drop CYC/STB, rsp_status = 01, rsp_dat = 0, go to RESP.
  - rty with retry count < MAX_RETRY: drop CYC/STB, increment count, go to GAP.
  - rty with retry count == MAX_RETRY: drop CYC/STB, rsp_status = 11, go to RESP.
  - ack: drop CYC/STB, rsp_status = 00. rsp_dat = wb_dat_i for reads, 0 for writes. Go to RESP.
  - No termination: increment the timeout counter. If TIMEOUT != 0 and the counter reaches TIMEOUT-1 at this edge, drop CYC/STB, rsp_status = 10, go to RESP.
- GAP: CYC/STB low for exactly one cycle. Then reassert with the same address, data and sel. Reset the timeout counter. Go to BUS.
- RESP:
  - rsp_valid = 1 with rsp_dat and rsp_status stable.
  - On rsp_ready: rsp_valid = 0, cmd_ready = 1, go to IDLE.
  - No new command is accepted in the same cycle as the response handshake.
- Latency: with a slave that registers ack one cycle after STB, command at edge N gives ack seen at edge N+2 and rsp_valid high from edge N+2. A held rsp_ready adds one cycle back to IDLE, so sustained throughput is one transfer per 4 cycles.
- CYC and STB are always asserted and deasserted together. wb_*_o are stable while CYC is high.
- Terminations seen while CYC is low are ignored.

Test Plan:
- Write 0x00000041 to 0xff000000, sel 4'hF, slave acks the next cycle -> wb_we_o = 1 and CYC high for exactly 2 cycles; rsp_status = 00, rsp_dat = 0; rsp_valid rises 2 cycles after the command handshake.
- Preload slave word 0x1000 = 0xdeadbeef, read cmd_adr 0x1002 -> wb_adr_o = 0x1000, rsp_dat = 0xdeadbeef, status 00.
- Slave asserts rty twice then ack, MAX_RETRY = 3 -> three CYC pulses each separated by one idle cycle; status 00. With rty always asserted -> four CYC pulses, then status 11.
- Slave never responds, TIMEOUT = 16 -> CYC high for exactly 16 cycles, then status 10, rsp_dat = 0.
- err and ack asserted in the same cycle -> status 01. Then hold rsp_ready low 5 cycles -> rsp_valid stays high, response fields stable, cmd_ready stays 0.
- Assert sys_rst while CYC is high -> CYC/STB low in the same cycle; after release cmd_ready = 1, rsp_valid = 0, and no bus activity occurs without a new command.

Source files
------------

// File: rtl/wb_cmd_master.sv
// +----------------------------------------------------------------------------+
// | wb_cmd_master: Wishbone classic single-transfer initiator driven by a      |
// | valid/ready command stream, with ERR/RTY/timeout handling.   Rev 1.0       |
// +----------------------------------------------------------------------------+
`default_nettype none

module wb_cmd_master #(
  parameter int TIMEOUT   = 1024,
  parameter int MAX_RETRY = 3
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic [1:0]  rsp_status,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [2:0]  wb_cti_o,
  output logic [1:0]  wb_bte_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i
);

  localparam int c_TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int c_RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT - 1);
  localparam logic [c_RW-1:0] c_RTY_MAX  = c_RW'(MAX_RETRY);

  localparam logic [1:0] c_ST_OK    = 2'b00;
  localparam logic [1:0] c_ST_ERR   = 2'b01;
  localparam logic [1:0] c_ST_TMO   = 2'b10;
  localparam logic [1:0] c_ST_RTYEX = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_GAP  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t            r_state;
  logic [c_TW-1:0]   r_tmo_cnt;
  logic [c_RW-1:0]   r_rty_cnt;

  // Word-aligned bus: the byte offset of the command address is dropped.
  logic w_unused;
  assign w_unused = ^cmd_adr[1:0];

  assign wb_cti_o = 3'b000;
  assign wb_bte_o = 2'b00;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state    <= S_IDLE;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_dat    <= 32'h0;
      rsp_status <= c_ST_OK;
      wb_adr_o   <= 32'h0;
      wb_dat_o   <= 32'h0;
      wb_sel_o   <= 4'h0;
      wb_we_o    <= 1'b0;
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      r_tmo_cnt  <= '0;
      r_rty_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            wb_adr_o  <= {cmd_adr[31:2], 2'b00};
            wb_dat_o  <= cmd_dat;
            wb_sel_o  <= cmd_sel;
            wb_we_o   <= cmd_we;
            wb_cyc_o  <= 1'b1;
            wb_stb_o  <= 1'b1;
            cmd_ready <= 1'b0;
            r_tmo_cnt <= '0;
            r_rty_cnt <= '0;
            r_state   <= S_BUS;
          end
        end

        S_BUS: begin
          if (wb_err_i) begin
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            rsp_status <= c_ST_ERR;
            rsp_dat    <= 32'h0;
            rsp_valid  <= 1'b1;
            r_state    <= S_RESP;
          end else if (wb_rty_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            if (r_rty_cnt < c_RTY_MAX) begin
              r_rty_cnt <= r_rty_cnt + 1'b1;
              r_state   <= S_GAP;
            end else begin
              rsp_status <= c_ST_RTYEX;
              rsp_dat    <= 32'h0;
              rsp_valid  <= 1'b1;
              r_state    <= S_RESP;
            end
          end else if (wb_ack_i) begin
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            rsp_status <= c_ST_OK;
            rsp_dat    <= wb_we_o ? 32'h0 : wb_dat_i;
            rsp_valid  <= 1'b1;
            r_state    <= S_RESP;
          end else if (TIMEOUT != 0) begin
            // The counter holds the number of unterminated edges already seen.
            if (r_tmo_cnt == c_TMO_LAST) begin
              wb_cyc_o   <= 1'b0;
              wb_stb_o   <= 1'b0;
              rsp_status <= c_ST_TMO;
              rsp_dat    <= 32'h0;
              rsp_valid  <= 1'b1;
              r_state    <= S_RESP;
            end else begin
              r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
          end
        end

        S_GAP: begin
          wb_cyc_o  <= 1'b1;
          wb_stb_o  <= 1'b1;
          r_tmo_cnt <= '0;
          r_state   <= S_BUS;
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
// +----------------------------------------------------------------------------+
// | tb_wb_cmd_master: directed bench for wb_cmd_master with a scripted slave.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_wb_cmd_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = 32'h0;
  logic [31:0] cmd_dat = 32'h0;
  logic [3:0]  cmd_sel = 4'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_rty_i;

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  // slave behaviour: 0 ack, 1 silent, 2 rty twice then ack, 3 err+ack, 4 always rty
  int mode = 0;
  int rty_base = 0;
  int s_rty_total = 0;

  int hi_total = 0;
  int pulse_total = 0;
  int we_total = 0;
  logic prev_cyc = 1'b0;
  logic [31:0] last_adr = 32'h0;

  wb_cmd_master #(.TIMEOUT(16), .MAX_RETRY(3)) dut (
    .sys_clk(clk), .sys_rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_status(rsp_status),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  always @(posedge clk) begin
    if (wb_cyc_o) hi_total <= hi_total + 1;
    if (wb_cyc_o && !prev_cyc) pulse_total <= pulse_total + 1;
    if (wb_cyc_o && wb_we_o) we_total <= we_total + 1;
    if (wb_cyc_o) last_adr <= wb_adr_o;
    prev_cyc <= wb_cyc_o;
  end

  // Registered slave: answers one cycle after it sees a strobe.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack_i <= 1'b0;
      wb_err_i <= 1'b0;
      wb_rty_i <= 1'b0;
      wb_dat_i <= 32'h0;
    end else begin
      wb_ack_i <= 1'b0;
      wb_err_i <= 1'b0;
      wb_rty_i <= 1'b0;
      if (wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i && !wb_rty_i) begin
        wb_dat_i <= (wb_adr_o == 32'h0000_1000) ? 32'hdead_beef : 32'ha5a5_a5a5;
        case (mode)
          0: wb_ack_i <= 1'b1;
          2: begin
            if (s_rty_total - rty_base < 2) begin
              wb_rty_i    <= 1'b1;
              s_rty_total <= s_rty_total + 1;
            end else begin
              wb_ack_i <= 1'b1;
            end
          end
          3: begin
            wb_err_i <= 1'b1;
            wb_ack_i <= 1'b1;
          end
          4: begin
            wb_rty_i    <= 1'b1;
            s_rty_total <= s_rty_total + 1;
          end
          default: ;
        endcase
      end
    end
  end

  task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, output int hs);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
    end
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    @(posedge clk);
    #1;
    hs = cycle;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int at);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    at = cycle;
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL rsp_wait: rsp_valid=%b after %0d cycles, required 1", rsp_valid, n);
    end
  endtask

  task automatic consume_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_handshake: cmd_ready=%b rsp_valid=%b, required 1 0", cmd_ready, rsp_valid);
    end
    checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) begin
      failures++;
      $display("FAIL reset_bus_ctl: cyc/stb/we=%b, required 000", {wb_cyc_o, wb_stb_o, wb_we_o});
    end
    checks++;
    if (wb_adr_o !== 32'h0 || wb_dat_o !== 32'h0 || wb_sel_o !== 4'h0) begin
      failures++;
      $display("FAIL reset_bus_data: adr=%h dat=%h sel=%h, required 0 0 0", wb_adr_o, wb_dat_o, wb_sel_o);
    end
    checks++;
    if (rsp_dat !== 32'h0 || rsp_status !== 2'b00 || wb_cti_o !== 3'b000 || wb_bte_o !== 2'b00) begin
      failures++;
      $display("FAIL reset_rsp: rsp_dat=%h status=%b cti=%b bte=%b, required 0 00 000 00",
               rsp_dat, rsp_status, wb_cti_o, wb_bte_o);
    end
  endtask

  task automatic test_write();
    int hs, at, hi0, we0;
    mode = 0;
    hi0 = hi_total;
    we0 = we_total;
    send_cmd(1'b1, 32'hff00_0000, 32'h0000_0041, 4'hf, hs);
    wait_rsp(at);
    checks++;
    if (at - hs != 2) begin
      failures++;
      $display("FAIL write_latency: got %0d cycles, required 2", at - hs);
    end
    checks++;
    if (hi_total - hi0 != 2 || we_total - we0 != 2) begin
      failures++;
      $display("FAIL write_cyc: cyc_high=%0d we_high=%0d, required 2 2", hi_total - hi0, we_total - we0);
    end
    checks++;
    if (rsp_status !== 2'b00 || rsp_dat !== 32'h0) begin
      failures++;
      $display("FAIL write_rsp: status=%b dat=%h, required 00 00000000", rsp_status, rsp_dat);
    end
    consume_rsp();
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL write_return: cmd_ready=%b rsp_valid=%b, required 1 0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_read();
    int hs, at;
    mode = 0;
    send_cmd(1'b0, 32'h0000_1002, 32'h0, 4'hf, hs);
    wait_rsp(at);
    checks++;
    if (last_adr !== 32'h0000_1000) begin
      failures++;
      $display("FAIL read_adr: wb_adr_o=%h, required 00001000", last_adr);
    end
    checks++;
    if (rsp_dat !== 32'hdead_beef || rsp_status !== 2'b00 || at - hs != 2) begin
      failures++;
      $display("FAIL read_rsp: dat=%h status=%b latency=%0d, required deadbeef 00 2",
               rsp_dat, rsp_status, at - hs);
    end
    consume_rsp();
  endtask

  task automatic test_timeout();
    int hs, at, hi0;
    mode = 1;
    hi0 = hi_total;
    send_cmd(1'b0, 32'h0000_1000, 32'h0, 4'hf, hs);
    wait_rsp(at);
    checks++;
    if (hi_total - hi0 != 16 || at - hs != 16) begin
      failures++;
      $display("FAIL timeout_len: cyc_high=%0d latency=%0d, required 16 16", hi_total - hi0, at - hs);
    end
    checks++;
    if (rsp_status !== 2'b10 || rsp_dat !== 32'h0) begin
      failures++;
      $display("FAIL timeout_rsp: status=%b dat=%h, required 10 00000000", rsp_status, rsp_dat);
    end
    consume_rsp();
  endtask

  task automatic test_retry();
    int hs, at, p0;
    mode = 2;
    rty_base = s_rty_total;
    p0 = pulse_total;
    send_cmd(1'b0, 32'h0000_1000, 32'h0, 4'hf, hs);
    wait_rsp(at);
    checks++;
    if (pulse_total - p0 != 3 || at - hs != 8) begin
      failures++;
      $display("FAIL retry_ok_pulses: pulses=%0d latency=%0d, required 3 8", pulse_total - p0, at - hs);
    end
    checks++;
    if (rsp_status !== 2'b00 || rsp_dat !== 32'hdead_beef) begin
      failures++;
      $display("FAIL retry_ok_rsp: status=%b dat=%h, required 00 deadbeef", rsp_status, rsp_dat);
    end
    consume_rsp();

    mode = 4;
    p0 = pulse_total;
    send_cmd(1'b0, 32'h0000_1000, 32'h0, 4'hf, hs);
    wait_rsp(at);
    checks++;
    if (pulse_total - p0 != 4 || at - hs != 11) begin
      failures++;
      $display("FAIL retry_ex_pulses: pulses=%0d latency=%0d, required 4 11", pulse_total - p0, at - hs);
    end
    checks++;
    if (rsp_status !== 2'b11 || rsp_dat !== 32'h0) begin
      failures++;
      $display("FAIL retry_ex_rsp: status=%b dat=%h, required 11 00000000", rsp_status, rsp_dat);
    end
    consume_rsp();
  endtask

  task automatic test_err_hold();
    int hs, at;
    mode = 3;
    send_cmd(1'b0, 32'h0000_1000, 32'h0, 4'hf, hs);
    wait_rsp(at);
    checks++;
    if (rsp_status !== 2'b01 || rsp_dat !== 32'h0) begin
      failures++;
      $display("FAIL err_rsp: status=%b dat=%h, required 01 00000000", rsp_status, rsp_dat);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_status !== 2'b01 || rsp_dat !== 32'h0 || cmd_ready !== 1'b0) begin
        failures++;
        $display("FAIL err_hold[%0d]: valid=%b status=%b dat=%h cmd_ready=%b, required 1 01 00000000 0",
                 i, rsp_valid, rsp_status, rsp_dat, cmd_ready);
      end
    end
    consume_rsp();
  endtask

  task automatic test_back_to_back();
    int hs1, hs2, at;
    mode = 0;
    rsp_ready = 1'b1;
    send_cmd(1'b1, 32'hffff_0000, 32'h1111_2222, 4'hf, hs1);
    send_cmd(1'b1, 32'hffff_0004, 32'h3333_4444, 4'h3, hs2);
    checks++;
    if (hs2 - hs1 != 4) begin
      failures++;
      $display("FAIL b2b_spacing: got %0d cycles, required 4", hs2 - hs1);
    end
    wait_rsp(at);
    checks++;
    if (at - hs2 != 2 || rsp_status !== 2'b00) begin
      failures++;
      $display("FAIL b2b_rsp: latency=%0d status=%b, required 2 00", at - hs2, rsp_status);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_midcycle();
    int hs, hi0;
    mode = 1;
    send_cmd(1'b0, 32'h0000_1000, 32'h0, 4'hf, hs);
    repeat (3) @(negedge clk);
    checks++;
    if (wb_cyc_o !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pre: cyc=%b, required 1", wb_cyc_o);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_async: cyc=%b stb=%b, required 0 0", wb_cyc_o, wb_stb_o);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_after: cmd_ready=%b rsp_valid=%b, required 1 0", cmd_ready, rsp_valid);
    end
    hi0 = hi_total;
    repeat (10) @(negedge clk);
    checks++;
    if (hi_total - hi0 != 0 || wb_cyc_o !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_quiet: cyc_high=%0d cyc=%b, required 0 0", hi_total - hi0, wb_cyc_o);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_retry();
    test_err_hold();
    test_back_to_back();
    test_reset_midcycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
